// File: rtl/perm_pkg.sv
// Shared constants and FSM state encoding for the nibble permutation unmapper.
package perm_pkg;
  localparam int unsigned NIBBLES = 16;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned WORD_W  = 64;

  typedef logic [NIB_W-1:0] nib_t;

  typedef enum logic [1:0] {
    READY = 2'd0,
    CHECK = 2'd1,
    ERROR = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_mux16.sv
// Selects one 4-bit nibble out of a 64-bit word.
module nibble_mux16
  import perm_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [NIB_W-1:0]  i_sel,
  output logic [NIB_W-1:0]  o_nib_c
);
  assign o_nib_c = i_word[{i_sel, 2'b00} +: NIB_W];
endmodule

// File: rtl/perm_unmapper.sv
// Inverts a configurable 16-nibble permutation (with optional per-word rotation)
// and validates each committed table by building its inverse one entry per cycle.
module perm_unmapper
  import perm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [NIB_W-1:0]  cfg_addr,
  input  logic [NIB_W-1:0]  cfg_data,
  input  logic              cfg_commit,
  input  logic              rot_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              cfg_busy,
  output logic              cfg_err
);
  localparam nib_t LAST_IDX = nib_t'(NIBBLES - 1);

  state_e              r_state;
  state_e              w_next;
  nib_t                r_p [NIBBLES];
  nib_t                r_q [NIBBLES];
  logic [NIBBLES-1:0]  r_seen;
  logic                r_dup;
  nib_t                r_idx;
  nib_t                r_k;
  logic                r_out_valid;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_err;

  logic                w_cfg_open;
  logic                w_commit;
  logic                w_accept;
  logic                w_last;
  logic                w_dup_now;
  nib_t                w_pidx;
  nib_t                w_shift;
  nib_t                w_sel [NIBBLES];
  logic [WORD_W-1:0]   w_restored;

  assign w_cfg_open = (r_state != CHECK);
  assign w_commit   = cfg_commit && w_cfg_open;
  assign in_ready   = (r_state == READY) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_pidx     = r_p[r_idx];
  assign w_last     = (r_idx == LAST_IDX);
  assign w_dup_now  = r_dup || r_seen[w_pidx];
  assign w_shift    = rot_en ? r_k : '0;

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign cfg_busy   = (r_state == CHECK);
  assign cfg_err    = r_err;

  // Output nibble j comes from input nibble (q[j] - k) mod 16.
  for (genvar j = 0; j < NIBBLES; j++) begin : g_lane
    assign w_sel[j] = nib_t'(r_q[j] - w_shift);
    nibble_mux16 u_mux (
      .i_word  (in_data),
      .i_sel   (w_sel[j]),
      .o_nib_c (w_restored[j*NIB_W +: NIB_W])
    );
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      READY, ERROR: if (cfg_commit) w_next = CHECK;
      CHECK:        if (w_last) w_next = w_dup_now ? ERROR : READY;
      default:      w_next = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= READY;
    else      r_state <= w_next;
  end

  // Forward table writes and the one-entry-per-cycle inverse build.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NIBBLES; i++) begin
        r_p[i] <= nib_t'(i);
        r_q[i] <= nib_t'(i);
      end
      r_seen <= '0;
      r_dup  <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (cfg_we && w_cfg_open) r_p[cfg_addr] <= cfg_data;
      if (w_commit) begin
        r_seen <= '0;
        r_dup  <= 1'b0;
        r_idx  <= '0;
      end else if (r_state == CHECK) begin
        r_q[w_pidx]    <= r_idx;
        r_seen[w_pidx] <= 1'b1;
        r_dup          <= w_dup_now;
        r_idx          <= nib_t'(r_idx + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_commit)                r_k <= '0;
      else if (w_accept && rot_en) r_k <= nib_t'(r_k + 1'b1);

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_restored;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if ((r_state == CHECK) && w_last) r_err <= w_dup_now;
    end
  end
endmodule

// File: tb/tb_perm_unmapper.sv
// Self-checking bench for perm_unmapper: vector table, random permutations
// against a forward-transform model, and hand-written config/backpressure/reset cases.
module tb_perm_unmapper;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = 4'd0;
  logic [3:0]  cfg_data = 4'd0;
  logic        cfg_commit = 1'b0;
  logic        rot_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, cfg_busy, cfg_err;
  logic [63:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int m_p [16];
  int m_k = 0;

  typedef struct {
    logic        rot;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  perm_unmapper dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .rot_en     (rot_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err)
  );

  // Forward transform: B.nib[i] = A.nib[p[(i+k) mod 16]].
  function automatic logic [63:0] fwd(input logic [63:0] a, input int k);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i*4 +: 4] = a[m_p[(i + k) % 16]*4 +: 4];
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_raw(input logic [63:0] b, input logic rot,
                          input logic [63:0] exp, input string name);
    int cyc;
    cyc = 0;
    in_data  = b;
    rot_en   = rot;
    in_valid = 1'b1;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_data"}, out_data, exp);
    if (rot) m_k = (m_k + 1) % 16;
  endtask

  task automatic send_word(input logic [63:0] a, input logic rot, input string name);
    send_raw(fwd(a, rot ? m_k : 0), rot, a, name);
  endtask

  task automatic load_and_commit(input int perm [16]);
    for (int i = 0; i < 16; i++) begin
      cfg_we     = 1'b1;
      cfg_addr   = 4'(perm[i]);
      cfg_addr   = 4'(i);
      cfg_data   = 4'(perm[i]);
      cfg_commit = (i == 15);
      @(negedge clk);
    end
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    m_k        = 0;
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (cfg_busy && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic shuffle(output int perm [16]);
    int j, t;
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int perm [16];
    int ident [16];
    int p031 [16];
    int cnt;
    logic [63:0] a1, a2;

    p031 = '{11, 1, 8, 5, 14, 13, 7, 4, 15, 0, 6, 12, 10, 3, 9, 2};
    for (int i = 0; i < 16; i++) begin
      ident[i] = i;
      m_p[i]   = i;
    end

    vecs[0] = '{1'b0, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    vecs[1] = '{1'b1, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    vecs[2] = '{1'b1, 64'h0FEDCBA987654321, 64'hFEDCBA9876543210};
    vecs[3] = '{1'b0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[4] = '{1'b1, 64'h10FEDCBA98765432, 64'hFEDCBA9876543210};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", 64'(cfg_busy), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Identity table vectors, including rotation k = 0, 1, 2
    for (int v = 0; v < 5; v++)
      send_raw(vecs[v].din, vecs[v].rot, vecs[v].exp, $sformatf("vec%0d", v));

    // Rotation counter wraps 15 -> 0
    while (m_k != 0) send_word({$urandom, $urandom}, 1'b1, "wrap_fill");
    send_raw(64'hFEDCBA9876543210, 1'b1, 64'hFEDCBA9876543210, "wrap_k0");

    // Reference table; last entry written in the same cycle as commit
    load_and_commit(p031);
    wait_busy(cnt);
    chk("p031_busy_cycles", 64'(cnt), 64'd16);
    chk("p031_err", 64'(cfg_err), 64'd0);
    m_p = p031;
    send_raw(64'h293AC60F47DE581B, 1'b0, 64'hFEDCBA9876543210, "p031_word");
    for (int w = 0; w < 4; w++) send_word({$urandom, $urandom}, 1'b1, "p031_rot");

    // Random permutations with random rotation enables
    for (int r = 0; r < 3; r++) begin
      shuffle(perm);
      load_and_commit(perm);
      wait_busy(cnt);
      chk($sformatf("rnd%0d_busy_cycles", r), 64'(cnt), 64'd16);
      chk($sformatf("rnd%0d_err", r), 64'(cfg_err), 64'd0);
      m_p = perm;
      for (int w = 0; w < 6; w++)
        send_word({$urandom, $urandom}, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_w%0d", r, w));
    end

    // Duplicate entry -> ERROR, no words accepted
    perm = ident;
    perm[3] = 7;
    perm[5] = 7;
    load_and_commit(perm);
    wait_busy(cnt);
    chk("dup_busy_cycles", 64'(cnt), 64'd16);
    chk("dup_err", 64'(cfg_err), 64'd1);
    chk("dup_in_ready", 64'(in_ready), 64'd0);
    in_data  = 64'h123456789ABCDEF0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("dup_in_ready_held", 64'(in_ready), 64'd0);
    chk("dup_no_accept", 64'(out_valid), 64'd0);
    in_valid = 1'b0;

    // Recovery; a write attempted during CHECK must be ignored
    load_and_commit(ident);
    cfg_we   = 1'b1;
    cfg_addr = 4'd15;
    cfg_data = 4'd5;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_busy(cnt);
    chk("recover_busy_cycles", 64'(cnt + 1), 64'd16);
    chk("recover_err", 64'(cfg_err), 64'd0);
    m_p = ident;
    send_word({$urandom, $urandom}, 1'b0, "recover_w0");
    send_word({$urandom, $urandom}, 1'b1, "recover_w1");

    // Backpressure: output held 5 cycles, then both words delivered once
    shuffle(perm);
    load_and_commit(perm);
    wait_busy(cnt);
    m_p = perm;
    @(negedge clk);
    a1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    out_ready = 1'b0;
    rot_en    = 1'b0;
    in_data   = fwd(a1, 0);
    in_valid  = 1'b1;
    @(negedge clk);
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    chk("bp_first_data", out_data, a1);
    in_data = fwd(a2, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_data", c), out_data, a1);
      chk($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_data", out_data, a2);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset in the middle of CHECK restores identity
    shuffle(perm);
    load_and_commit(perm);
    repeat (5) @(negedge clk);
    chk("midchk_busy", 64'(cfg_busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midchk_rst_busy", 64'(cfg_busy), 64'd0);
    chk("midchk_rst_err", 64'(cfg_err), 64'd0);
    chk("midchk_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_p = ident;
    m_k = 0;
    chk("midchk_in_ready", 64'(in_ready), 64'd1);
    send_raw(64'hFEDCBA9876543210, 1'b0, 64'hFEDCBA9876543210, "midchk_ident");
    send_word({$urandom, $urandom}, 1'b1, "midchk_rot0");
    send_word({$urandom, $urandom}, 1'b1, "midchk_rot1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/perm_unmapper.md
PERM_UNMAPPER -- requirements
Module: perm_unmapper

Interface
REQ-001 Parameters: none; nibble count fixed at 16 and word width at 64.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 cfg_we  in  1  write one forward-table entry.
REQ-005 cfg_addr  in  4  output nibble position i.
REQ-006 cfg_data  in  4  source nibble p[i].
REQ-007 cfg_commit  in  1  start table check and inverse build.
REQ-008 rot_en  in  1  undo per-word nibble rotation.
REQ-009 in_valid/in_ready  in/out  1/1  permuted-word handshake.
REQ-010 in_data  in  64  permuted word B.
REQ-011 out_valid/out_ready  out/in  1/1  restored-word handshake.
REQ-012 out_data  out  64  restored word A.
REQ-013 cfg_busy, cfg_err  out  1/1  check running; last committed table not a bijection.

Function
REQ-014 Forward transform: B.nib[i] = A.nib[p[(i+k) mod 16]], with k = 4-bit count of words accepted since last commit or reset when rot_en=1, else k=0; block SHALL output A.nib[j] = B.nib[(q[j]-k) mod 16], q = p inverse.
REQ-015 FSM states READY, CHECK, ERROR; reset state READY.
REQ-016 cfg_we writes p[cfg_addr]=cfg_data in READY or ERROR; ignored in CHECK.
REQ-017 cfg_commit in READY/ERROR -> CHECK next cycle; k cleared to 0; cfg_commit ignored in CHECK; cfg_we and cfg_commit in same cycle: write applied first, commit sees new entry.
REQ-018 CHECK scans idx 0..15, one per cycle: q[p[idx]]=idx, sets seen[p[idx]]; any duplicate sets error flag.
REQ-019 After idx 15 (16 cycles in CHECK): -> READY with cfg_err=0 if no duplicate, else -> ERROR with cfg_err=1.
REQ-020 cfg_busy=1 exactly while in CHECK.
REQ-021 in_ready = (state==READY) && (!out_valid || out_ready).
REQ-022 Accepted word produces out_valid=1 next cycle (latency 1); out_data held stable while out_valid && !out_ready.
REQ-023 k increments mod 16 on each accepted word when rot_en=1; wraps 15->0.
REQ-024 Word pending in output register at commit drains normally; no new accepts until READY.
REQ-025 In ERROR, in_ready=0; exit only via new commit or reset.

Reset
REQ-026 On rst low: p and q = identity, seen cleared, k=0, state READY, out_valid=0, out_data=0, cfg_busy=0, cfg_err=0.
REQ-027 Reset during CHECK abandons the scan; table returns to identity.

Structure
REQ-028 Shared package perm_pkg holds NIBBLES=16, NIB_W=4, WORD_W=64, and the FSM state enum.
REQ-029 One sub-module nibble_mux16 (64-bit word, 4-bit index -> 4-bit nibble), instantiated 16 times in the datapath.

Verification
REQ-030 After reset, rot_en=0, in 0xFEDCBA9876543210 -> out same value one cycle later.
REQ-031 Load p=[11,1,8,5,14,13,7,4,15,0,6,12,10,3,9,2], commit, wait 16 cycles; in 0x293AC60F47DE581B -> out 0xFEDCBA9876543210.
REQ-032 Identity table, rot_en=1: in 0xFEDCBA9876543210 then 0x0FEDCBA987654321 -> both outputs 0xFEDCBA9876543210; after 16 words k wraps to 0.
REQ-033 p[3]=p[5]=7, commit -> cfg_busy high 16 cycles, then cfg_err=1, in_ready=0; reload valid table and commit -> cfg_err=0.
REQ-034 out_ready=0 for 5 cycles with word pending -> out_data stable, in_ready=0, no word lost or duplicated.
REQ-035 Assert rst mid-CHECK -> cfg_busy=0, state READY, identity mapping restored.
